// File: rtl/afe_buf_wr_arbiter.sv
// Round-robin write arbiter between per-ADC sample holding registers and the
// shared sample-buffer SRAM write port (grant/ack with the address generators).
module afe_buf_wr_arbiter #(
  parameter int unsigned NUM_ADC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_AWIDTH = 10
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_ADC-1:0]                  adc_valid_i,
  input  logic [NUM_ADC-1:0][DATA_WIDTH-1:0]  adc_data_i,
  input  logic [NUM_ADC-1:0]                  adc_buf_en_i,
  input  logic [NUM_ADC-1:0][BUF_AWIDTH-1:0]  adc_buf_addr_i,
  output logic [NUM_ADC-1:0]                  adc_grant_o,
  input  logic [NUM_ADC-1:0]                  adc_grant_ack_i,
  output logic                                buf_req_o,
  output logic [BUF_AWIDTH-1:0]               buf_addr_o,
  output logic [DATA_WIDTH-1:0]               buf_wdata_o,
  input  logic                                buf_gnt_i,
  output logic [NUM_ADC-1:0]                  drop_o
);

  localparam int unsigned PTR_W = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_e;

  state_e                             state_q, state_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d, win_q, win_d, win_inc;
  logic [PTR_W-1:0]                   pick_idx;
  logic                               pick_found;
  int unsigned                        scan_idx;
  logic [NUM_ADC-1:0]                 pending_q, pend_clr, abort_drop, accept, drop_d;
  logic [NUM_ADC-1:0][DATA_WIDTH-1:0] hold_q;
  logic [NUM_ADC-1:0]                 grant_d;
  logic                               req_d;
  logic [BUF_AWIDTH-1:0]              addr_d;
  logic [DATA_WIDTH-1:0]              wdata_d;
  logic                               ack_win, en_win;

  assign ack_win = adc_grant_ack_i[win_q];
  assign en_win  = adc_buf_en_i[win_q];
  assign win_inc = (win_q == PTR_W'(NUM_ADC - 1)) ? '0 : win_q + PTR_W'(1);

  // First pending index at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < NUM_ADC; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_ADC;
      if (!pick_found && pending_q[PTR_W'(scan_idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          win_d   = pick_idx;
        end
      end
      GRANT: begin
        if (ack_win) begin
          state_d = WRITE;
        end else if (!en_win) begin
          state_d = IDLE;
          ptr_d   = win_inc;
        end
      end
      WRITE: begin
        if (buf_gnt_i) begin
          state_d = IDLE;
          ptr_d   = win_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the pending-clear strobe.
  always_comb begin
    grant_d    = adc_grant_o;
    req_d      = buf_req_o;
    addr_d     = buf_addr_o;
    wdata_d    = buf_wdata_o;
    pend_clr   = '0;
    abort_drop = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) grant_d = NUM_ADC'(1) << pick_idx;
      end
      GRANT: begin
        if (ack_win) begin
          grant_d = '0;
          req_d   = 1'b1;
          addr_d  = adc_buf_addr_i[win_q];
          wdata_d = hold_q[win_q];
        end else if (!en_win) begin
          grant_d             = '0;
          pend_clr[win_q]     = 1'b1;
          abort_drop[win_q]   = 1'b1;
        end
      end
      WRITE: begin
        if (buf_gnt_i) begin
          req_d           = 1'b0;
          pend_clr[win_q] = 1'b1;
        end
      end
      default: grant_d = '0;
    endcase
  end

  // A slot being freed this cycle can take a new sample without a drop.
  assign accept = adc_valid_i & (~pending_q | pend_clr);
  assign drop_d = (adc_valid_i & pending_q & ~pend_clr) | abort_drop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q   <= '0;
      hold_q      <= '0;
      adc_grant_o <= '0;
      buf_req_o   <= 1'b0;
      buf_addr_o  <= '0;
      buf_wdata_o <= '0;
      drop_o      <= '0;
    end else begin
      pending_q   <= adc_valid_i | (pending_q & ~pend_clr);
      for (int unsigned k = 0; k < NUM_ADC; k++) begin
        if (accept[k]) hold_q[k] <= adc_data_i[k];
      end
      adc_grant_o <= grant_d;
      buf_req_o   <= req_d;
      buf_addr_o  <= addr_d;
      buf_wdata_o <= wdata_d;
      drop_o      <= drop_d;
    end
  end

endmodule

// File: tb/tb_afe_buf_wr_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_afe_buf_wr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [N-1:0]         valid;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0]         en;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0]         grant;
  logic [N-1:0]         ack;
  logic                 req;
  logic [AW-1:0]        baddr;
  logic [DW-1:0]        bwdata;
  logic                 gnt;
  logic [N-1:0]         drop;

  always #5 clk = ~clk;

  afe_buf_wr_arbiter #(.NUM_ADC(N), .DATA_WIDTH(DW), .BUF_AWIDTH(AW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .adc_valid_i(valid), .adc_data_i(data),
    .adc_buf_en_i(en), .adc_buf_addr_i(addr),
    .adc_grant_o(grant), .adc_grant_ack_i(ack),
    .buf_req_o(req), .buf_addr_o(baddr), .buf_wdata_o(bwdata),
    .buf_gnt_i(gnt), .drop_o(drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: which ADC is being served and whether its write is out.
  bit            m_pend [N];
  logic [DW-1:0] m_hold [N];
  bit            m_clr  [N];
  int            m_ptr     = 0;
  int            m_srv     = -1;
  bit            m_writing = 0;
  bit            m_found;
  logic [N-1:0]  e_grant = '0;
  logic [N-1:0]  e_drop  = '0;
  logic          e_req   = 1'b0;
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_wdata = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_hold[k] = '0; end
      m_ptr = 0; m_srv = -1; m_writing = 0;
      e_grant = '0; e_drop = '0; e_req = 1'b0; e_addr = '0; e_wdata = '0;
    end else begin
      for (int k = 0; k < N; k++) m_clr[k] = 0;
      e_drop = '0;
      if (m_srv < 0) begin
        m_found = 0;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (!m_found && m_pend[j]) begin
            m_found = 1; m_srv = j; m_writing = 0;
            e_grant = '0; e_grant[j] = 1'b1;
          end
        end
      end else if (!m_writing) begin
        if (ack[m_srv]) begin
          e_addr = addr[m_srv]; e_wdata = m_hold[m_srv];
          e_grant = '0; e_req = 1'b1; m_writing = 1;
        end else if (!en[m_srv]) begin
          e_grant = '0; m_clr[m_srv] = 1; e_drop[m_srv] = 1'b1;
          m_ptr = (m_srv + 1) % N; m_srv = -1;
        end
      end else if (gnt) begin
        m_clr[m_srv] = 1; e_req = 1'b0;
        m_ptr = (m_srv + 1) % N; m_srv = -1;
      end
      for (int k = 0; k < N; k++) begin
        if (valid[k]) begin
          if (m_pend[k] && !m_clr[k]) e_drop[k] = 1'b1;
          else begin m_hold[k] = data[k]; m_pend[k] = 1; end
        end else if (m_clr[k]) begin
          m_pend[k] = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_grant", grant, e_grant);
    chk("cyc_req", req, e_req);
    chk("cyc_drop", drop, e_drop);
    if (e_req) begin
      chk("cyc_addr", baddr, e_addr);
      chk("cyc_wdata", bwdata, e_wdata);
    end
  end

  int drop_cnt [N];
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) if (drop[k]) drop_cnt[k]++;
  end

  int gq[$];

  task automatic collect_grants(input int n);
    gq.delete();
    for (int c = 0; c < 40 && gq.size() < n; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (grant[k]) gq.push_back(k);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, req, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  initial begin
    int seen;
    rstn = 1'b0; valid = '0; data = '0; en = '1; addr = '0; ack = '0; gnt = 1'b0;
    for (int k = 0; k < N; k++) drop_cnt[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0); chk("rst_req", req, 0); chk("rst_drop", drop, 0);
    chk("rst_addr", baddr, 0); chk("rst_wdata", bwdata, 0);
    @(negedge clk); rstn = 1'b1;

    // Single sample, immediate ack and gnt
    @(negedge clk);
    valid = 4'b0010; data[1] = 32'hA5A5_0001; addr[1] = 10'h010; ack = '1; gnt = 1'b1;
    @(posedge clk); #1; chk("single_t1_grant", grant, 4'b0000);
    @(negedge clk); valid = '0;
    @(posedge clk); #1; chk("single_t2_grant", grant, 4'b0010); chk("single_t2_req", req, 0);
    @(posedge clk); #1; chk("single_t3_req", req, 1); chk("single_t3_grant", grant, 0);
    chk("single_t3_addr", baddr, 10'h010); chk("single_t3_wdata", bwdata, 32'hA5A5_0001);
    @(posedge clk); #1; chk("single_t4_req", req, 0);

    // Round-robin from pointer 0, then wrap
    do_reset();
    @(negedge clk);
    valid = '1;
    for (int k = 0; k < N; k++) begin data[k] = 32'h100 + k; addr[k] = AW'(10'h20 + k); end
    @(negedge clk); valid = '0;
    collect_grants(4);
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) chk("rr_order", gq[i], i);
    repeat (3) @(posedge clk);
    @(negedge clk); valid = 4'b0101;
    @(negedge clk); valid = '0;
    collect_grants(2);
    chk("rr2_count", gq.size(), 2);
    if (gq.size() == 2) begin chk("rr2_first", gq[0], 0); chk("rr2_second", gq[1], 2); end
    repeat (4) @(posedge clk);

    // Overflow on ADC3 with the buffer stalled
    @(negedge clk); gnt = 1'b0; drop_cnt[3] = 0; valid = 4'b1000; data[3] = 32'hD1D1_0003;
    @(negedge clk); valid = '0;
    @(negedge clk); valid = 4'b1000; data[3] = 32'hD2D2_0003;
    @(negedge clk); valid = '0;
    repeat (3) @(negedge clk);
    chk("ovf_drop_cnt", drop_cnt[3], 1);
    chk("ovf_req", req, 1);
    chk("ovf_wdata", bwdata, 32'hD1D1_0003);
    gnt = 1'b1;
    @(posedge clk); #1; chk("ovf_done", req, 0);
    repeat (2) @(posedge clk);

    // Clear-and-refill of ADC0
    @(negedge clk); gnt = 1'b0; valid = 4'b0001; data[0] = 32'h0000_C0DE; addr[0] = 10'h055;
    @(negedge clk); valid = '0;
    wait_req("refill_req1");
    @(negedge clk); gnt = 1'b1; valid = 4'b0001; data[0] = 32'h0000_BEEF;
    @(posedge clk); #1; chk("refill_nodrop", drop, 0); chk("refill_req_off", req, 0);
    @(negedge clk); valid = '0;
    wait_req("refill_req2");
    chk("refill_wdata2", bwdata, 32'h0000_BEEF);
    repeat (3) @(posedge clk);

    // Disabled buffer on ADC2: abort after one GRANT cycle
    @(negedge clk); ack = '0; en = 4'b1011; valid = 4'b0100; data[2] = 32'h2222_0002;
    @(negedge clk); valid = '0;
    @(posedge clk); #1; chk("dis_grant", grant, 4'b0100);
    @(posedge clk); #1; chk("dis_drop", drop, 4'b0100); chk("dis_grant_off", grant, 0);
    chk("dis_req", req, 0);
    @(negedge clk); en = '1; ack = '1; valid = 4'b1010;
    @(negedge clk); valid = '0;
    collect_grants(2);
    chk("dis_ptr_count", gq.size(), 2);
    if (gq.size() == 2) begin chk("dis_ptr_first", gq[0], 3); chk("dis_ptr_second", gq[1], 1); end
    repeat (4) @(posedge clk);

    // Reset while a write is outstanding
    @(negedge clk); gnt = 1'b0; valid = 4'b0010; data[1] = 32'h0BAD_0001;
    @(negedge clk); valid = '0;
    wait_req("rstw_req");
    @(negedge clk); #2; rstn = 1'b0;
    #1; chk("rstw_req_off", req, 0); chk("rstw_grant_off", grant, 0); chk("rstw_drop", drop, 0);
    @(negedge clk); rstn = 1'b1; gnt = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (req || grant != '0) seen++;
    end
    chk("rstw_no_write", seen, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < N; k++) begin
        valid[k] = ($urandom_range(0, 3) == 0);
        en[k]    = ($urandom_range(0, 9) != 0);
        ack[k]   = $urandom_range(0, 1) == 1;
        data[k]  = $urandom;
        addr[k]  = AW'($urandom);
      end
      gnt = $urandom_range(0, 1) == 1;
    end
    @(negedge clk); rstn = 1'b1; valid = '0;
    repeat (5) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_buf_wr_arbiter.md
Name: afe_buf_wr_arbiter

Overview:
- Sits directly downstream of the per-ADC top blocks and their sample-buffer address generators, upstream of the shared sample-buffer SRAM port.
- Captures each ADC's synchronized sample pulse in a one-entry holding register.
- Arbitrates round-robin among pending ADCs and runs the grant/ack handshake with the winner's buffer address generator.
- Issues one buffer write per sample, using the address that generator supplies.

Parameters:
- NUM_ADC, 4, number of ADC tops arbitrated.
- DATA_WIDTH, 32, sample width (matches the ADC synchronized data width).
- BUF_AWIDTH, 10, sample-buffer word address width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- adc_valid_i  in  NUM_ADC  per-ADC synchronized sample-valid pulse.
- adc_data_i  in  NUM_ADC x DATA_WIDTH  per-ADC synchronized sample data.
- adc_buf_en_i  in  NUM_ADC  per-ADC buffer address generator enabled.
- adc_buf_addr_i  in  NUM_ADC x BUF_AWIDTH  per-ADC current buffer address.
- adc_grant_o  out  NUM_ADC  one-hot grant to the address generators.
- adc_grant_ack_i  in  NUM_ADC  write-grant acknowledge from the address generators.
- buf_req_o  out  1  buffer write request.
- buf_addr_o  out  BUF_AWIDTH  buffer write address.
- buf_wdata_o  out  DATA_WIDTH  buffer write data.
- buf_gnt_i  in  1  buffer accepted the write this cycle.
- drop_o  out  NUM_ADC  one-cycle pulse: sample k lost.

Behaviour:
- Reset: all outputs 0, all pending flags 0, round-robin pointer 0, state IDLE.
- Per ADC k:
  - adc_valid_i[k] with pending[k]=0 captures adc_data_i[k] into hold[k]; pending[k]=1 next cycle.
  - adc_valid_i[k] while pending[k]=1 and not being cleared this cycle: the new sample is discarded, hold[k] is kept, and drop_o[k]=1 next cycle.
  - If pending[k] is cleared in the same cycle as a new valid arrives, the new sample is accepted and there is no drop.
- FSM states: IDLE, GRANT, WRITE.
  - IDLE: if any pending, pick the first pending index at or after the pointer (wrapping modulo NUM_ADC) as win. Go to GRANT; adc_grant_o is set one-hot at win (registered). Otherwise stay in IDLE.
  - GRANT: hold adc_grant_o[win].
    - If adc_grant_ack_i[win]=1: latch buf_addr_o=adc_buf_addr_i[win] and buf_wdata_o=hold[win], clear adc_grant_o, set buf_req_o, go to WRITE.
    - Else if adc_buf_en_i[win]=0: abort. Clear adc_grant_o, clear pending[win], pulse drop_o[win], advance pointer to win+1, go to IDLE.
    - Ack takes priority over the abort check in the same cycle.
  - WRITE: buf_req_o, buf_addr_o and buf_wdata_o stay stable until buf_gnt_i=1. In that cycle: clear pending[win], pointer=win+1 mod NUM_ADC, buf_req_o=0 next cycle, go to IDLE.
- Latency with immediate ack/gnt (valid at cycle t):
  - t+1: pending set.
  - t+2: grant.
  - t+3: buf_req_o.
  - t+4: back to IDLE.
  - Peak throughput: one write every 3 cycles.
- Grant, ack and req are never asserted for more than one ADC at a time.
- Acks on non-winning indices are ignored.
- buf_addr_o and buf_wdata_o are only meaningful while buf_req_o=1; otherwise they hold their last value.
- Reset mid-operation clears everything asynchronously. Any in-flight sample is lost without a drop pulse.

Test Plan:
- Single sample: ADC1 valid with data 0xA5A5_0001, ack immediate, addr 0x010, gnt immediate -> adc_grant_o=4'b0010 at t+2; buf_req_o at t+3 with addr 0x010 and data 0xA5A5_0001; IDLE at t+4.
- Round-robin: all 4 ADCs valid in the same cycle with pointer 0 -> writes in order 0,1,2,3. Then ADC0 and ADC2 valid again -> ADC0 is served first (pointer wrapped to 0).
- Overflow: ADC3 valid twice, 1 cycle apart, while buf_gnt_i is held 0 -> drop_o[3] pulses once; the eventual write carries the first sample's data.
- Clear-and-refill: ADC0 valid in the same cycle its buf_gnt_i completes -> no drop; a second write for ADC0 follows.
- Disabled buffer: ADC2 pending, adc_buf_en_i[2]=0, no ack -> abort after 1 GRANT cycle; drop_o[2]=1; no buf_req_o; pointer=3.
- Reset asserted while in WRITE with buf_req_o=1 -> buf_req_o, adc_grant_o and pending all 0 immediately; after release, no write occurs.
